// File: rtl/rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rob_commit_ctrl
// Description : ROB head/tail/occupancy owner. Grants dispatch allocations at
//               the tail, retires the head entry in order once it is valid and
//               done, and emits a registered commit record for the arch RAT.
//               Stores at the head are held until the LSU acknowledges them.
//               Optional macro ROB_COMMIT_PERF_EN enables the retire and stall
//               performance counters. Without it the perf ports read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_commit_ctrl #(
    parameter int ROB_LENGTH      = 16,
    parameter int ROB_IDX_W       = 4,
    parameter int ARCH_REG_IDX_W  = 5,
    parameter int PHYS_REG_IDX_W  = 6,
    parameter int INT_DATA_W      = 32,
    parameter int INSTR_MEM_IDX_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_req,
    output logic                       alloc_ready,
    output logic                       rob_write,
    output logic [ROB_IDX_W-1:0]       rob_tail,
    output logic [ROB_IDX_W-1:0]       rob_head,
    input  logic                       head_valid,
    input  logic                       head_done,
    input  logic                       head_is_store,
    input  logic [INSTR_MEM_IDX_W-1:0] head_pc,
    input  logic [ARCH_REG_IDX_W-1:0]  head_logical_rd,
    input  logic [PHYS_REG_IDX_W-1:0]  head_phys_rd,
    input  logic [INT_DATA_W-1:0]      head_result,
    output logic                       store_commit_req,
    input  logic                       store_ack,
    input  logic                       flush_req,
    output logic                       commit_valid,
    output logic                       commit_rd_we,
    output logic [INSTR_MEM_IDX_W-1:0] commit_pc,
    output logic [ARCH_REG_IDX_W-1:0]  commit_logical_rd,
    output logic [PHYS_REG_IDX_W-1:0]  commit_phys_rd,
    output logic [INT_DATA_W-1:0]      commit_result,
    output logic [ROB_IDX_W:0]         rob_count,
    output logic [31:0]                perf_retired,
    output logic [31:0]                perf_stall_cycles
);

    localparam logic [0:0]         c_ST_RUN        = 1'b0;
    localparam logic [0:0]         c_ST_STORE_WAIT = 1'b1;
    localparam logic [ROB_IDX_W:0] c_FULL          = (ROB_IDX_W+1)'(ROB_LENGTH);

    logic [0:0]                 state_q, state_d;
    logic [ROB_IDX_W-1:0]       head_q, head_d;
    logic [ROB_IDX_W-1:0]       tail_q, tail_d;
    logic [ROB_IDX_W:0]         count_q, count_d;
    logic                       flush_pending_q, flush_pending_d;
    logic                       commit_valid_q, commit_valid_d;
    logic                       commit_rd_we_q, commit_rd_we_d;
    logic [INSTR_MEM_IDX_W-1:0] commit_pc_q, commit_pc_d;
    logic [ARCH_REG_IDX_W-1:0]  commit_rd_q, commit_rd_d;
    logic [PHYS_REG_IDX_W-1:0]  commit_prd_q, commit_prd_d;
    logic [INT_DATA_W-1:0]      commit_res_q, commit_res_d;

    logic w_alloc_fire;
    logic w_eligible;
    logic w_retire;
    logic w_flush_run;
    logic w_flush_after;

    // Both states accept allocations, so readiness depends only on occupancy
    // and on the flush input; the registered count keeps it free of retire.
    assign alloc_ready      = (count_q != c_FULL) & ~flush_req;
    assign rob_write        = alloc_req & alloc_ready;
    assign store_commit_req = (state_q == c_ST_STORE_WAIT);
    assign rob_head         = head_q;
    assign rob_tail         = tail_q;
    assign rob_count        = count_q;

    assign commit_valid      = commit_valid_q;
    assign commit_rd_we      = commit_rd_we_q;
    assign commit_pc         = commit_pc_q;
    assign commit_logical_rd = commit_rd_q;
    assign commit_phys_rd    = commit_prd_q;
    assign commit_result     = commit_res_q;

    // Retire/flush decisions and next-state for pointers, FSM and commit record
    always_comb begin
        w_alloc_fire  = alloc_req & alloc_ready;
        w_eligible    = (count_q != '0) & head_valid & head_done;
        w_flush_run   = (state_q == c_ST_RUN) & flush_req;
        w_retire      = ((state_q == c_ST_RUN) & ~flush_req & w_eligible & ~head_is_store)
                      | ((state_q == c_ST_STORE_WAIT) & store_ack);
        w_flush_after = (state_q == c_ST_STORE_WAIT) & store_ack & (flush_pending_q | flush_req);

        state_d         = state_q;
        flush_pending_d = flush_pending_q;
        head_d          = head_q + ROB_IDX_W'(w_retire);
        tail_d          = tail_q + ROB_IDX_W'(w_alloc_fire);
        count_d         = count_q + (ROB_IDX_W+1)'(w_alloc_fire) - (ROB_IDX_W+1)'(w_retire);

        if (state_q == c_ST_RUN) begin
            if (~flush_req & w_eligible & head_is_store) begin
                state_d = c_ST_STORE_WAIT;
            end
        end else begin
            if (store_ack) begin
                state_d         = c_ST_RUN;
                flush_pending_d = 1'b0;
            end else if (flush_req) begin
                flush_pending_d = 1'b1;
            end
        end

        // A flush keeps the head where it is; only the uncommitted tail collapses.
        if (w_flush_run) begin
            tail_d  = head_q;
            count_d = '0;
        end else if (w_flush_after) begin
            tail_d  = head_q + ROB_IDX_W'(1);
            count_d = '0;
        end

        commit_valid_d = w_retire;
        commit_rd_we_d = commit_rd_we_q;
        commit_pc_d    = commit_pc_q;
        commit_rd_d    = commit_rd_q;
        commit_prd_d   = commit_prd_q;
        commit_res_d   = commit_res_q;
        if (w_retire) begin
            commit_rd_we_d = ~head_is_store & (head_logical_rd != '0);
            commit_pc_d    = head_pc;
            commit_rd_d    = head_logical_rd;
            commit_prd_d   = head_phys_rd;
            commit_res_d   = head_result;
        end
    end

    // Control and commit-record registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= c_ST_RUN;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            flush_pending_q <= 1'b0;
            commit_valid_q  <= 1'b0;
            commit_rd_we_q  <= 1'b0;
            commit_pc_q     <= '0;
            commit_rd_q     <= '0;
            commit_prd_q    <= '0;
            commit_res_q    <= '0;
        end else begin
            state_q         <= state_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            flush_pending_q <= flush_pending_d;
            commit_valid_q  <= commit_valid_d;
            commit_rd_we_q  <= commit_rd_we_d;
            commit_pc_q     <= commit_pc_d;
            commit_rd_q     <= commit_rd_d;
            commit_prd_q    <= commit_prd_d;
            commit_res_q    <= commit_res_d;
        end
    end

`ifdef ROB_COMMIT_PERF_EN
    logic [31:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Retire count and cycles where the ROB holds work but nothing retires
    always_comb begin
        perf_retired_d = perf_retired_q + 32'(w_retire);
        perf_stall_d   = perf_stall_q + 32'((count_q != '0) & ~w_retire);
    end

    // Perf counters survive flushes; only reset clears them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_retired_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_retired_q <= perf_retired_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_retired      = perf_retired_q;
    assign perf_stall_cycles = perf_stall_q;
`else
    assign perf_retired      = 32'd0;
    assign perf_stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire
